// File: rtl/mips_dbg_pkg.sv
// +----------------------------------------------------------------------------+
// | mips_dbg_pkg : shared types and width helpers for the MIPS run controller. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_dbg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALTED = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  // Index width that stays >= 1 even for a single-entry structure.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_probe_mux.sv
// +----------------------------------------------------------------------------+
// | mips_probe_mux : NCH:1 registered probe selector, out-of-range select -> 0.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_probe_mux #(
  parameter int DATA_W = 32,
  parameter int NCH    = 8,
  parameter int SW     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NCH*DATA_W-1:0] probe_i,
  input  logic [SW-1:0]         slct_i,
  output logic [DATA_W-1:0]     result_o
);

  logic [DATA_W-1:0] result_d;
  logic [DATA_W-1:0] result_q;

  always_comb begin
    result_d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (slct_i == SW'(k)) result_d = probe_i[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) result_q <= '0;
    else         result_q <= result_d;
  end

  assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/mips_run_ctrl.sv
// +----------------------------------------------------------------------------+
// | mips_run_ctrl : IMEM loader, run/step/halt sequencer, cycle counter and    |
// | probe readout. Optional breakpoint unit: RUN_CTRL_BREAKPOINT_EN.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NCH        = 8,
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = idx_w(IMEM_DEPTH),
  parameter int SW         = idx_w(NCH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_req_i,
  input  logic                  load_valid_i,
  input  logic                  load_last_i,
  input  logic [DATA_W-1:0]     load_data_i,
  output logic                  load_ready_o,
  input  logic                  run_i,
  input  logic                  step_i,
  input  logic                  halt_i,
  input  logic [DATA_W-1:0]     pc_i,
  input  logic [NCH*DATA_W-1:0] probe_i,
  input  logic [SW-1:0]         slct_i,
  output logic                  core_en_o,
  output logic                  core_rst_n_o,
  output logic                  imem_we_o,
  output logic [AW-1:0]         imem_addr_o,
  output logic [DATA_W-1:0]     imem_wdata_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [STATE_W-1:0]    state_o,
  output logic [DATA_W-1:0]     cycle_cnt_o
`ifdef RUN_CTRL_BREAKPOINT_EN
  ,
  input  logic [DATA_W-1:0]     bkpt_addr_i,
  input  logic                  bkpt_arm_i,
  output logic                  bkpt_hit_o
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       load_cnt_q;
  logic [AW-1:0]       imem_addr_q;
  logic [DATA_W-1:0]   imem_wdata_q;
  logic                imem_we_q;
  logic                core_rst_n_q;
  logic [DATA_W-1:0]   cycle_cnt_q;
  logic                accept;
  logic                bkpt_match;
  logic                load_start;

  assign accept     = load_ready_o && load_valid_i;
  assign load_start = (state_q == ST_HALTED) && (state_d == ST_LOAD);

`ifdef RUN_CTRL_BREAKPOINT_EN
  logic first_run_q;
  logic bkpt_hit_q;

  // The first RUN cycle is masked so a restart from the breakpoint PC proceeds.
  assign bkpt_match = (state_q == ST_RUN) && bkpt_arm_i && !first_run_q &&
                      (pc_i == bkpt_addr_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_run_q <= 1'b1;
      bkpt_hit_q  <= 1'b0;
    end else begin
      first_run_q <= (state_q != ST_RUN);
      if (bkpt_match)
        bkpt_hit_q <= 1'b1;
      else if ((state_q == ST_HALTED) && ((state_d == ST_RUN) || (state_d == ST_STEP)))
        bkpt_hit_q <= 1'b0;
    end
  end

  assign bkpt_hit_o = bkpt_hit_q;
`else
  assign bkpt_match = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_HALTED;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED: begin
        if (load_req_i)  state_d = ST_LOAD;
        else if (run_i)  state_d = ST_RUN;
        else if (step_i) state_d = ST_STEP;
      end
      ST_LOAD: begin
        if (accept && (load_last_i || (load_cnt_q == LAST_ADDR))) state_d = ST_HALTED;
      end
      ST_RUN: begin
        if (halt_i || !run_i || bkpt_match) state_d = ST_HALTED;
      end
      ST_STEP: state_d = ST_HALTED;
      default: state_d = ST_HALTED;
    endcase
  end

  always_comb begin
    core_en_o    = 1'b0;
    load_ready_o = 1'b0;
    case (state_q)
      ST_LOAD: load_ready_o = 1'b1;
      ST_RUN:  core_en_o    = !bkpt_match;
      ST_STEP: core_en_o    = 1'b1;
      default: ;
    endcase
  end

  // The load counter parks at the last address; leaving LOAD stops acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_cnt_q   <= '0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      imem_we_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      cycle_cnt_q  <= '0;
    end else begin
      imem_we_q    <= accept;
      core_rst_n_q <= (state_d != ST_LOAD);
      if (accept) begin
        imem_addr_q  <= load_cnt_q;
        imem_wdata_q <= load_data_i;
        if (load_cnt_q != LAST_ADDR) load_cnt_q <= load_cnt_q + 1'b1;
      end else if (load_start) begin
        load_cnt_q <= '0;
      end
      if (load_start)     cycle_cnt_q <= '0;
      else if (core_en_o) cycle_cnt_q <= cycle_cnt_q + 1'b1;
    end
  end

  mips_probe_mux #(
    .DATA_W (DATA_W),
    .NCH    (NCH),
    .SW     (SW)
  ) u_probe_mux (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .probe_i  (probe_i),
    .slct_i   (slct_i),
    .result_o (result_o)
  );

  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_rst_n_o = core_rst_n_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign state_o      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_run_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mips_run_ctrl : directed vector table plus run/step/reset sequences.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mips_run_ctrl;

  localparam int DW  = 32;
  localparam int NCH = 5;
  localparam int DEP = 4;
  localparam int AW  = 2;
  localparam int SW  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_req = 0, load_valid = 0, load_last = 0;
  logic [DW-1:0] load_data = '0;
  logic          run = 0, step = 0, halt = 0;
  logic [DW-1:0] pc = '0;
  logic          pc_auto = 1'b0;
  logic [NCH*DW-1:0] probe;
  logic [SW-1:0] slct = '0;
  logic          load_ready, core_en, core_rst_n, imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata, result, cycle_cnt;
  logic [1:0]    state;
`ifdef RUN_CTRL_BREAKPOINT_EN
  logic [DW-1:0] bkpt_addr = 32'h0000_000C;
  logic          bkpt_arm = 1'b0;
  logic          bkpt_hit;
`endif

  int tests = 0;
  int fails = 0;

  assign probe = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!pc_auto)     pc <= '0;
    else if (core_en) pc <= pc + 32'd4;
  end

  mips_run_ctrl #(.DATA_W(DW), .NCH(NCH), .IMEM_DEPTH(DEP)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .load_req_i   (load_req),
    .load_valid_i (load_valid),
    .load_last_i  (load_last),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .run_i        (run),
    .step_i       (step),
    .halt_i       (halt),
    .pc_i         (pc),
    .probe_i      (probe),
    .slct_i       (slct),
    .core_en_o    (core_en),
    .core_rst_n_o (core_rst_n),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_wdata_o (imem_wdata),
    .result_o     (result),
    .state_o      (state),
    .cycle_cnt_o  (cycle_cnt)
`ifdef RUN_CTRL_BREAKPOINT_EN
    ,
    .bkpt_addr_i  (bkpt_addr),
    .bkpt_arm_i   (bkpt_arm),
    .bkpt_hit_o   (bkpt_hit)
`endif
  );

  typedef struct {
    logic          lr, lv, ll;
    logic [DW-1:0] ld;
    logic          rn, st, hl;
    logic [SW-1:0] sl;
    logic [1:0]    e_state;
    logic          e_en, e_rdy, e_crn, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_cc, e_res;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                lr lv ll ld            rn st hl sl | st en rdy crn we addr wd            cc  res
    vecs.push_back('{0, 0, 0, 32'h0,         0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 32'h0,         0, 32'h1111_1111});
    vecs.push_back('{1, 0, 0, 32'h0,         0, 0, 0, 1,   1, 0, 1, 0, 0, 0, 32'h0,         0, 32'h2222_2222});
    vecs.push_back('{0, 1, 0, 32'h2001_0005, 0, 0, 0, 2,   1, 0, 1, 0, 1, 0, 32'h2001_0005, 0, 32'hDEAD_BEEF});
    vecs.push_back('{0, 1, 0, 32'h2002_0003, 0, 0, 0, 3,   1, 0, 1, 0, 1, 1, 32'h2002_0003, 0, 32'h3333_3333});
    vecs.push_back('{0, 1, 1, 32'h0022_1820, 0, 0, 0, 4,   0, 0, 0, 1, 1, 2, 32'h0022_1820, 0, 32'h4444_4444});
    vecs.push_back('{0, 0, 0, 32'h0,         0, 0, 0, 2,   0, 0, 0, 1, 0, 2, 32'h0022_1820, 0, 32'hDEAD_BEEF});
    vecs.push_back('{1, 0, 0, 32'h0,         1, 0, 0, 5,   1, 0, 1, 0, 0, 2, 32'h0022_1820, 0, 32'h0});
    vecs.push_back('{0, 1, 0, 32'hA0,        1, 1, 1, 0,   1, 0, 1, 0, 1, 0, 32'hA0,        0, 32'h1111_1111});
    vecs.push_back('{1, 1, 0, 32'hA1,        0, 0, 0, 0,   1, 0, 1, 0, 1, 1, 32'hA1,        0, 32'h1111_1111});
    vecs.push_back('{0, 1, 0, 32'hA2,        0, 0, 0, 0,   1, 0, 1, 0, 1, 2, 32'hA2,        0, 32'h1111_1111});
    vecs.push_back('{0, 1, 0, 32'hA3,        0, 0, 0, 0,   0, 0, 0, 1, 1, 3, 32'hA3,        0, 32'h1111_1111});
    vecs.push_back('{0, 1, 0, 32'hA4,        0, 0, 0, 7,   0, 0, 0, 1, 0, 3, 32'hA3,        0, 32'h0});
    vecs.push_back('{0, 1, 0, 32'hA5,        0, 0, 0, 6,   0, 0, 0, 1, 0, 3, 32'hA3,        0, 32'h0});

    // Reset state while reset is held across clock edges.
    repeat (2) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_ready", 32'(load_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_core_rst_n", 32'(core_rst_n), 32'd0);

    foreach (vecs[i]) begin
      load_req = vecs[i].lr; load_valid = vecs[i].lv; load_last = vecs[i].ll;
      load_data = vecs[i].ld; run = vecs[i].rn; step = vecs[i].st;
      halt = vecs[i].hl; slct = vecs[i].sl;
      tick();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("v%0d_core_en", i), 32'(core_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_ready", i), 32'(load_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_core_rst_n", i), 32'(core_rst_n), 32'(vecs[i].e_crn));
      chk($sformatf("v%0d_we", i), 32'(imem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_wdata", i), imem_wdata, vecs[i].e_wd);
      chk($sformatf("v%0d_cycle", i), cycle_cnt, vecs[i].e_cc);
      chk($sformatf("v%0d_result", i), result, vecs[i].e_res);
    end
    load_req = 0; load_valid = 0; load_last = 0; run = 0; step = 0; halt = 0; slct = '0;

    // Free run for 10 cycles, halted by a HALT pulse with RUN still high.
    run = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("run%0d_en", i), 32'(core_en), 32'd1);
      chk($sformatf("run%0d_cnt", i), cycle_cnt, 32'(i));
      if (i == 9) halt = 1'b1;
      tick();
    end
    halt = 1'b0; run = 1'b0;
    #1;
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_en", 32'(core_en), 32'd0);
    chk("halt_cycle", cycle_cnt, 32'd10);

    // RUN dropping to 0 ends free-run after the in-flight cycle.
    run = 1'b1; tick();
    run = 1'b0; tick();
    chk("rundrop_state", 32'(state), 32'd0);
    chk("rundrop_cycle", cycle_cnt, 32'd11);

    // Three single-step pulses.
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; tick();
      chk($sformatf("step%0d_en", i), 32'(core_en), 32'd1);
      chk($sformatf("step%0d_state", i), 32'(state), 32'd3);
      step = 1'b0; tick();
      chk($sformatf("step%0d_off", i), 32'(core_en), 32'd0);
    end
    chk("step_cycle", cycle_cnt, 32'd14);

    // STEP held high steps every other cycle.
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d_en", i), 32'(core_en), (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    step = 1'b0;
    chk("hold_cycle", cycle_cnt, 32'd16);

    // Reset asserted mid-load aborts further writes.
    load_req = 1'b1; tick();
    load_req = 1'b0; load_valid = 1'b1; load_data = 32'hB0; tick();
    chk("midld_we", 32'(imem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(imem_we), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_crn", 32'(core_rst_n), 32'd0);
    tick();
    chk("midrst_we2", 32'(imem_we), 32'd0);
    rst_n = 1'b1; load_valid = 1'b0;
    tick();
    chk("midrel_state", 32'(state), 32'd0);
    chk("midrel_crn", 32'(core_rst_n), 32'd1);
    chk("midrel_we", 32'(imem_we), 32'd0);

`ifdef RUN_CTRL_BREAKPOINT_EN
    begin
      bit halted_seen;
      halted_seen = 1'b0;
      pc_auto = 1'b1; bkpt_arm = 1'b1; run = 1'b1;
      tick();
      for (int i = 0; i < 20 && !halted_seen; i++) begin
        if (state == 2'd2 && pc == 32'h0C) chk("bkpt_en_blocked", 32'(core_en), 32'd0);
        tick();
        if (state == 2'd0) halted_seen = 1'b1;
      end
      run = 1'b0;
      chk("bkpt_halted", 32'(halted_seen), 32'd1);
      chk("bkpt_pc", pc, 32'h0C);
      chk("bkpt_hit", 32'(bkpt_hit), 32'd1);
      chk("bkpt_cycle", cycle_cnt, 32'd3);
      tick();
      chk("bkpt_sticky", 32'(bkpt_hit), 32'd1);
      run = 1'b1; tick();
      chk("rerun_hit_clr", 32'(bkpt_hit), 32'd0);
      chk("rerun_en", 32'(core_en), 32'd1);
      repeat (2) tick();
      chk("rerun_past", 32'(pc > 32'h0C), 32'd1);
      chk("rerun_state", 32'(state), 32'd2);
      run = 1'b0; tick();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Run/debug controller for the MIPS core. It replaces the fixed WE/W_Ins load path and SLCT result mux with a parametrised, handshaked sequencer:
- streams instruction words into IMEM while holding the core in reset;
- gates the core with a clock enable for free-run, single-step and halt;
- counts executed cycles;
- presents one of NCH registered probe channels on RESULT for the LCD.

Parameters:
DATA_W, 32, width of instruction words, probe channels, PC and cycle counter
NCH, 8, number of probe channels on PROBE (>=2)
IMEM_DEPTH, 64, IMEM words; AW = $clog2(IMEM_DEPTH), SW = $clog2(NCH)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  asynchronous, active-low reset
LOAD_REQ  in  1  pulse: start instruction load
LOAD_VALID  in  1  load word valid
LOAD_LAST  in  1  qualifies final word (with LOAD_VALID)
LOAD_DATA  in  DATA_W  instruction word
LOAD_READY  out  1  controller accepts load words
RUN  in  1  level: free-run request
STEP  in  1  pulse: execute exactly one core cycle
HALT  in  1  pulse: stop free-run
PC  in  DATA_W  core program counter
PROBE  in  NCH*DATA_W  concatenated channels; channel k = bits [k*DATA_W +: DATA_W]
SLCT  in  SW  probe channel select
CORE_EN  out  1  core clock enable
CORE_RST_N  out  1  core reset, active-low
IMEM_WE  out  1  IMEM write strobe
IMEM_ADDR  out  AW  IMEM word address
IMEM_WDATA  out  DATA_W  IMEM write data
RESULT  out  DATA_W  registered selected probe
STATE  out  2  FSM state
CYCLE_CNT  out  DATA_W  count of CORE_EN cycles

Behaviour:
- Reset (RST=0, asynchronous) sets:
  - state HALTED, LOAD_READY=0, IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0;
  - RESULT=0, CYCLE_CNT=0, CORE_RST_N=0.
  - CORE_RST_N rises on the first CLK edge after RST release, unless that edge enters LOAD.
- States: HALTED=0, LOAD=1, RUN=2, STEP=3.
- HALTED:
  - next-state priority is LOAD_REQ > RUN > STEP;
  - LOAD_REQ -> LOAD: clears the address counter and CYCLE_CNT;
  - RUN=1 -> RUN;
  - STEP -> STEP.
- LOAD:
  - LOAD_READY=1 and CORE_RST_N=0 (registered);
  - each cycle with LOAD_VALID=1 registers IMEM_WE=1, IMEM_WDATA=LOAD_DATA and IMEM_ADDR=counter. Write appears 1 cycle after acceptance; counter increments.
  - LOAD_LAST, or acceptance at counter=IMEM_DEPTH-1, -> HALTED. Counter does not wrap; excess words are never accepted.
  - RUN, STEP and HALT are ignored. LOAD_REQ during LOAD is ignored.
  - Leaving LOAD releases CORE_RST_N next edge, so the core restarts at PC reset.
- RUN:
  - CORE_EN=1 combinationally from state;
  - HALT pulse or RUN=0 -> HALTED. CORE_EN is still 1 in that cycle; the transition takes effect at the edge.
  - HALT wins over RUN=1 in the same cycle.
- STEP:
  - CORE_EN=1 for exactly one cycle, then HALTED;
  - a STEP held high for N cycles yields one step per HALTED->STEP visit, i.e. every other cycle.
- CORE_EN=0 in HALTED and LOAD.
- CYCLE_CNT: +1 on every CLK edge with CORE_EN=1; wraps at 2^DATA_W-1 -> 0.
- RESULT: registered PROBE channel SLCT every cycle in all states, latency 1. SLCT>=NCH gives 0.
- Reset mid-LOAD: aborts the load, with no further IMEM_WE. Words already written stay written.

Optional Feature:
- Macro RUN_CTRL_BREAKPOINT_EN.
- Defined: adds ports BKPT_ADDR in DATA_W, BKPT_ARM in 1 and BKPT_HIT out 1.
  - In RUN, when BKPT_ARM=1 and PC==BKPT_ADDR: CORE_EN forced 0 that cycle (breakpoint instruction not executed), next state HALTED, BKPT_HIT set (sticky).
  - BKPT_HIT is cleared on entry to RUN or STEP; reset value 0.
  - Compare is masked in the first RUN cycle after HALTED, so a restart from the breakpoint PC proceeds.
  - STEP ignores the breakpoint.
- Undefined: ports absent; RUN is halted only by HALT or RUN=0.

Decomposition:
- Package mips_dbg_pkg: state enum (HALTED/LOAD/RUN/STEP, 2-bit), state encodings, localparam helpers for AW/SW.
- One sub-module: mips_probe_mux, a parametrised NCH:1 registered selector with out-of-range zeroing. FSM, load counter and cycle counter stay in mips_run_ctrl.

Test Plan:
- Reset, then release -> all outputs 0 and STATE=0; CORE_RST_N=1 after first edge.
- LOAD_REQ, then 3 words 0x20010005, 0x20020003, 0x00221820, LAST on the third:
  - IMEM_WE pulses at addresses 0,1,2 with matching data;
  - STATE returns to 0; CORE_RST_N is low throughout LOAD.
- IMEM_DEPTH=4, 6 words streamed without LAST -> exactly 4 writes (addr 0-3); LOAD_READY drops after the 4th; words 5-6 are not accepted.
- RUN high 10 cycles, then HALT pulse concurrent with RUN=1 -> CORE_EN high 10 cycles, low after the HALT edge; CYCLE_CNT=10.
- Three STEP pulses from HALTED -> three single-cycle CORE_EN pulses; CYCLE_CNT=3. SLCT=2 with PROBE ch2=0xDEADBEEF -> RESULT=0xDEADBEEF one cycle later. SLCT=7 with NCH=5 -> RESULT=0.
- With RUN_CTRL_BREAKPOINT_EN, BKPT_ADDR=0x0C, PC advancing by 4 from 0, RUN=1:
  - halts with PC=0x0C and BKPT_HIT=1; CYCLE_CNT=3;
  - a re-RUN advances past 0x0C.
